// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the uart_rx_deser receiver
//
// Contents:
//   uart_rx_state_t      receiver FSM states (IDLE, START, DATA, STOP)
//   UART_N_BITS_DEF      default data bits per frame
//   UART_OVERSAMPLE_DEF  default clk cycles per bit
//   maj3()               2-of-3 majority vote, used when UART_RX_MAJORITY_EN is defined
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int UART_N_BITS_DEF     = 9;
  localparam int UART_OVERSAMPLE_DEF = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-FF synchroniser for the raw rx line with falling-edge detect
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset, all flops reset to 1 (idle line)
//   rx_i       raw serial line, asynchronous to clk
//   rx_s_o     synchronised line
//   rx_fall_o  one-cycle pulse on the first cycle rx_s_o is low after being high
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_s_o,
  output logic rx_fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s_o    = sync_q;
  assign rx_fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - oversampling UART receiver with valid/ready word output
//
// Parameters:
//   N_BITS      data bits per frame, LSB first (1..16)
//   OVERSAMPLE  clk cycles per bit, even (4..256)
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   rx           raw serial line, idle high
//   data_o       last accepted word
//   valid_o      data_o holds an unconsumed word
//   ready_i      downstream accepts when valid_o && ready_i
//   run          active low: 0 while a frame is in progress
//   frame_err_o  one-cycle pulse when the stop bit is sampled low
//   overrun_o    one-cycle pulse when a good frame is dropped
// Build option:
//   UART_RX_MAJORITY_EN  2-of-3 majority around each mid-bit point,
//                        decisions move one cycle later
module uart_rx_deser
  import uart_rx_pkg::*;
#(
  parameter int N_BITS     = UART_N_BITS_DEF,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [N_BITS-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              run,
  output logic              frame_err_o,
  output logic              overrun_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(N_BITS + 1);

  // START counts from the falling edge, so its decision is half a bit in;
  // every later decision is one full bit after the previous one.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] START_TICK = TW'(OVERSAMPLE / 2);
`else
  localparam logic [TW-1:0] START_TICK = TW'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [TW-1:0] BIT_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(N_BITS - 1);

  logic rx_s;
  logic rx_fall;
  logic sample;

  uart_rx_state_t    state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [N_BITS-1:0] shreg_q, shreg_d;
  logic [N_BITS-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx),
    .rx_s_o    (rx_s),
    .rx_fall_o (rx_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is rx_s one cycle ago, hist_q[1] two cycles ago, so at the
  // decision tick the vote covers mid-1, mid and mid+1.
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign sample = maj3(hist_q[1], hist_q[0], rx_s);
`else
  assign sample = rx_s;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (rx_fall) begin
          tick_d  = '0;
          state_d = START;
        end
      end

      START: begin
        if (tick_q == START_TICK) begin
          if (sample) begin
            state_d = IDLE;
          end else begin
            tick_d   = '0;
            bitcnt_d = '0;
            state_d  = DATA;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      DATA: begin
        if (tick_q == BIT_TICK) begin
          for (int i = 0; i < N_BITS; i++) begin
            if (bitcnt_q == BW'(i)) begin
              shreg_d[i] = sample;
            end
          end
          tick_d = '0;
          if (bitcnt_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      STOP: begin
        if (tick_q == BIT_TICK) begin
          state_d = IDLE;
          if (sample) begin
            // A handshake on this same cycle frees the slot, so the load wins.
            if (!valid_q || ready_i) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    run         = (state_q == IDLE);
    data_o      = data_q;
    valid_o     = valid_q;
    frame_err_o = ferr_q;
    overrun_o   = ovr_q;
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb/tb_uart_rx_deser.sv - directed self-checking bench for uart_rx_deser
module tb_uart_rx_deser;

  localparam int NB = 9;
  localparam int OS = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          ready_i;
  logic [NB-1:0] data_o;
  logic          valid_o;
  logic          run;
  logic          frame_err_o;
  logic          overrun_o;

  int checks = 0;
  int errors = 0;

  int            first_valid, first_ferr, first_ovr;
  int            valid_cnt, ferr_cnt, ovr_cnt;
  int            run_lo_min, run_lo_max;
  logic [NB-1:0] data_at_valid;
  logic [NB-1:0] snap_data;
  logic          snap_valid, snap_run, snap_ferr, snap_ovr;

  always #5 clk = ~clk;

  uart_rx_deser #(.N_BITS(NB), .OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .run         (run),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // rx level at cycle c of a frame: start bit, NB data bits, stop bit, then idle.
  function automatic logic frame_level(input logic [15:0] w, input logic sb, input int c,
                                       input int glitch_len, input logic spikes);
    int   b;
    int   t;
    logic v;
    b = c / OS;
    t = c % OS;
    if (glitch_len > 0) return (c < glitch_len) ? 1'b0 : 1'b1;
    if (b == 0) v = 1'b0;
    else if (b <= NB) v = w[b-1];
    else if (b == NB + 1) v = sb;
    else v = 1'b1;
    if (spikes && b >= 1 && b <= NB && t == OS / 2) v = ~v;
    return v;
  endfunction

  // Entered and left just after a rising edge; cycle 0 is the cycle rx falls.
  task automatic run_frame(input logic [15:0] w, input logic sb, input int ncyc,
                           input int abort_at, input int glitch_len, input logic spikes);
    logic spell_done;
    first_valid = -1; first_ferr = -1; first_ovr = -1;
    valid_cnt = 0; ferr_cnt = 0; ovr_cnt = 0;
    run_lo_min = -1; run_lo_max = -1;
    spell_done = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (abort_at >= 0 && c == abort_at) rst = 1'b1;
      if (abort_at >= 0 && c == abort_at + 3) rst = 1'b0;
      if (abort_at >= 0 && c >= abort_at) rx = 1'b1;
      else rx = frame_level(w, sb, c, glitch_len, spikes);
      @(negedge clk);
      if (valid_o === 1'b1) begin
        valid_cnt++;
        if (first_valid < 0) begin
          first_valid   = c;
          data_at_valid = data_o;
        end
      end
      if (frame_err_o === 1'b1) begin
        ferr_cnt++;
        if (first_ferr < 0) first_ferr = c;
      end
      if (overrun_o === 1'b1) begin
        ovr_cnt++;
        if (first_ovr < 0) first_ovr = c;
      end
      if (run === 1'b0 && !spell_done) begin
        if (run_lo_min < 0) run_lo_min = c;
        run_lo_max = c;
      end else if (run_lo_min >= 0) begin
        spell_done = 1'b1;
      end
      if (c == abort_at) begin
        snap_data  = data_o;
        snap_valid = valid_o;
        snap_run   = run;
        snap_ferr  = frame_err_o;
        snap_ovr   = overrun_o;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst     = 1'b1;
    rx      = 1'b1;
    ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data", int'(data_o), 0);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_run", int'(run), 1);
    chk("reset_ferr", int'(frame_err_o), 0);
    chk("reset_ovr", int'(overrun_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Good frame 0x1A5, downstream always ready
    ready_i = 1'b1;
    run_frame(16'h1A5, 1'b1, 200, -1, 0, 1'b0);
    chk("good_valid_cycle", first_valid, 171 + MAJ);
    chk("good_data", int'(data_at_valid), 'h1A5);
    chk("good_valid_pulse_len", valid_cnt, 1);
    chk("good_run_low_first", run_lo_min, 3);
    chk("good_run_low_last", run_lo_max, 170 + MAJ);
    chk("good_no_ferr", ferr_cnt, 0);
    chk("good_no_ovr", ovr_cnt, 0);

    // 4-cycle glitch: false start, back to idle
    run_frame(16'h000, 1'b1, 40, -1, 4, 1'b0);
    chk("glitch_run_low_first", run_lo_min, 3);
    chk("glitch_run_low_last", run_lo_max, 10 + MAJ);
    chk("glitch_run_end", int'(run), 1);
    chk("glitch_no_valid", valid_cnt, 0);
    chk("glitch_no_ferr", ferr_cnt, 0);
    chk("glitch_no_ovr", ovr_cnt, 0);

    // Frame 0x0FF with a low stop bit
    run_frame(16'h0FF, 1'b0, 220, -1, 0, 1'b0);
    chk("ferr_cycle", first_ferr, 171 + MAJ);
    chk("ferr_pulse_len", ferr_cnt, 1);
    chk("ferr_no_valid", valid_cnt, 0);
    chk("ferr_data_kept", int'(data_o), 'h1A5);

    // Two frames with downstream stalled: second one overruns
    ready_i = 1'b0;
    run_frame(16'h011, 1'b1, 190, -1, 0, 1'b0);
    chk("ovr_first_valid_cycle", first_valid, 171 + MAJ);
    chk("ovr_first_data", int'(data_at_valid), 'h011);
    run_frame(16'h022, 1'b1, 190, -1, 0, 1'b0);
    chk("ovr_cycle", first_ovr, 171 + MAJ);
    chk("ovr_pulse_len", ovr_cnt, 1);
    chk("ovr_data_kept", int'(data_o), 'h011);
    chk("ovr_valid_held", int'(valid_o), 1);
    ready_i = 1'b1;
    @(negedge clk);
    chk("ovr_valid_at_handshake", int'(valid_o), 1);
    @(negedge clk);
    chk("ovr_valid_after_handshake", int'(valid_o), 0);
    @(posedge clk);
    #1;

    // Reset mid-frame, then a clean 0x155 frame
    run_frame(16'h155, 1'b1, 120, 80, 0, 1'b0);
    chk("rst_mid_data", int'(snap_data), 0);
    chk("rst_mid_valid", int'(snap_valid), 0);
    chk("rst_mid_run", int'(snap_run), 1);
    chk("rst_mid_ferr", int'(snap_ferr), 0);
    chk("rst_mid_ovr", int'(snap_ovr), 0);
    chk("rst_partial_no_valid", valid_cnt, 0);
    run_frame(16'h155, 1'b1, 200, -1, 0, 1'b0);
    chk("after_rst_valid_cycle", first_valid, 171 + MAJ);
    chk("after_rst_data", int'(data_o), 'h155);

`ifdef UART_RX_MAJORITY_EN
    // Single-cycle inverted spike at each data bit's mid tick
    run_frame(16'h0AA, 1'b1, 200, -1, 0, 1'b1);
    chk("maj_valid_cycle", first_valid, 172);
    chk("maj_data", int'(data_at_valid), 'h0AA);
    chk("maj_no_ferr", ferr_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Oversampling UART/bit-stream receiver that sits directly downstream of the start-detect/run-gating stage in the CAN decoder input path. It synchronises the raw `rx` line to the system clock, qualifies the start bit, samples `N_BITS` data bits at mid-bit, checks the stop bit, and presents each completed word on a valid/ready handshake. It also exports an active-low `run` flag that matches the upstream convention, so the two stages can be cross-checked.

## Interface
- `N_BITS`, 9: data bits per frame, LSB first, range 1..16.
- `OVERSAMPLE`, 16: clk cycles per bit, even, range 4..256.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx` input 1: raw serial line, idle high, asynchronous to `clk`.
- `data_o` output N_BITS: last accepted word.
- `valid_o` output 1: `data_o` holds an unconsumed word.
- `ready_i` input 1: downstream accepts the word when `valid_o && ready_i`.
- `run` output 1: active low; 0 while a frame is in progress (START, DATA, STOP), 1 in IDLE.
- `frame_err_o` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_o` output 1: one-cycle pulse when a good frame is dropped because `valid_o` is still high.

## Operation
- `rx` passes through a 2-FF synchroniser (`rx_s`). All decisions use `rx_s` only.
- FSM states, with transitions:
  - IDLE: wait for `rx_s` == 0. On that cycle, clear the tick counter and go to START.
  - START: when tick == OVERSAMPLE/2-1, sample `rx_s`. If it is 1, this is a false start: go to IDLE with no flags raised. If it is 0, clear tick and bitcnt and go to DATA.
  - DATA: when tick == OVERSAMPLE-1, shift the sample in as `shreg[bitcnt]` (LSB first) and clear tick. After bit N_BITS-1, go to STOP.
  - STOP: when tick == OVERSAMPLE-1, sample `rx_s`.
    - Sample 1 and `valid_o` == 0: load `data_o <= shreg` and set `valid_o`.
    - Sample 1 and `valid_o` == 1: pulse `overrun_o`; `data_o` keeps the old word.
    - Sample 0: pulse `frame_err_o`; `data_o` and `valid_o` are unchanged.
    - In every case go to IDLE. This happens at mid stop bit, which allows back-to-back frames.
- `valid_o` clears on the cycle after the `valid_o && ready_i` handshake. If a new word loads on the same cycle as a handshake, the load wins: `valid_o` stays 1 and `data_o` holds the new word, with no overrun.
- Widths:
  - tick counter is `$clog2(OVERSAMPLE)` bits.
  - bitcnt is `$clog2(N_BITS+1)` bits.
  - Neither counter ever wraps past its terminal value; it clears explicitly.
- Reset can arrive mid-frame. It forces IDLE and discards the partial frame. Reset values:
  - `data_o` = 0, `valid_o` = 0, `run` = 1
  - `frame_err_o` = 0, `overrun_o` = 0
  - synchroniser flops = 1, `shreg` = 0.

## Timing
- Cycle numbering starts at 0 on the cycle `rx` falls: `rx_s` falls at cycle 2 and the FSM leaves IDLE at cycle 2.
- Sample points:
  - Start sample: cycle 2+OVERSAMPLE/2.
  - Data bit k: cycle 2+OVERSAMPLE/2+OVERSAMPLE·(k+1).
  - Stop sample: cycle 2+OVERSAMPLE/2+OVERSAMPLE·(N_BITS+1).
- `valid_o`, `frame_err_o` and `overrun_o` assert one cycle after the stop sample.
- `run` goes low one cycle after IDLE is left and returns high one cycle after the stop sample.
- `ready_i` may be held high permanently. Throughput is one word per frame; there is no combinational path from `ready_i` to `valid_o`.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each start, data and stop decision is the 2-of-3 majority of `rx_s` at ticks mid-1, mid and mid+1.
  - The decision is registered at mid+1, so every sample point and every output moves one cycle later.
- Undefined: a single sample is taken at mid, with the timing given above.

## Structure
- Package `uart_rx_pkg`:
  - state enum `uart_rx_state_t` (IDLE, START, DATA, STOP)
  - default constants `UART_N_BITS_DEF` = 9 and `UART_OVERSAMPLE_DEF` = 16.
- Sub-module `uart_rx_sync`: the 2-FF synchroniser, reset to 1. It outputs `rx_s`, plus `rx_fall` for the IDLE exit.

## Test plan
All scenarios use N_BITS = 9 and OVERSAMPLE = 16, with the macro undefined unless stated.
- Frame 0x1A5 with a good stop bit, `ready_i` = 1 → `valid_o` pulses at cycle 171 with `data_o` = 0x1A5; `run` is low for cycles 3..170.
- Glitch: `rx` low for 4 cycles only → no state beyond START, `run` returns to 1, no `valid_o`, no errors.
- Frame 0x0FF with the stop bit driven low → `frame_err_o` pulses at cycle 171; `valid_o` stays 0.
- `ready_i` = 0, frames 0x011 then 0x022 → `data_o` = 0x011, `overrun_o` pulses at the end of the second frame; after `ready_i` goes high, `valid_o` drops.
- `rst` asserted at cycle 80 mid-frame, followed by a clean 0x155 frame → all outputs at reset values during `rst`; `data_o` = 0x155 afterwards.
- `UART_RX_MAJORITY_EN` defined, 0x0AA with a 1-cycle inverted spike at each data bit's mid tick → `data_o` = 0x0AA, with `valid_o` at cycle 172.
